// File: rtl/mem_ctrl.sv
// Byte-serial memory bus controller: arbitrates the single 8-bit RAM/IO port between
// instruction fetch (word reads) and the load/store buffer, splitting accesses into byte beats.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_WAIT = 2'd1,
        XFER    = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [2:0]  len_reg, len_next;
    logic [2:0]  beat_reg, beat_next;
    logic        store_reg, store_next;
    logic        owner_lsb_reg, owner_lsb_next;
    logic [31:0] result_reg, result_next;
    logic        if_done_reg, if_done_next;
    logic        lsb_done_reg, lsb_done_next;
    logic [31:0] if_data_reg, if_data_next;
    logic [31:0] lsb_rdata_reg, lsb_rdata_next;

    logic [7:0]  wbyte [4];
    logic [7:0]  cap_byte [4];
    logic [31:0] result_cap;
    logic [2:0]  cap_idx;
    logic [2:0]  beat_idx;
    logic        beat_live;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // In XFER with beat_reg = c, byte c is issued and byte c-1 (loads) is captured.
    assign cap_idx = beat_reg - 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi]    = wdata_reg[8*gi +: 8];
            assign cap_byte[gi] = (cap_idx == 3'(gi)) ? mem_din : result_reg[8*gi +: 8];
            assign result_cap[8*gi +: 8] = cap_byte[gi];
        end
    endgenerate

    // A stalled load keeps the oldest uncaptured byte on the bus so its data is valid on resume.
    assign beat_idx  = (!rdy_in && !store_reg && beat_reg != 3'd0) ? cap_idx : beat_reg;
    assign beat_live = (state_reg == XFER) && (beat_idx < len_reg);
    assign mem_a     = beat_live ? addr_reg + {29'd0, beat_idx} : 32'd0;
    assign mem_wr    = beat_live && store_reg && rdy_in;
    assign mem_dout  = (beat_live && store_reg) ? wbyte[beat_idx[1:0]] : 8'd0;
    assign busy      = (state_reg != IDLE);

    assign if_done   = if_done_reg;
    assign if_data   = if_data_reg;
    assign lsb_done  = lsb_done_reg;
    assign lsb_rdata = lsb_rdata_reg;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg     <= IDLE;
            addr_reg      <= 32'd0;
            wdata_reg     <= 32'd0;
            len_reg       <= 3'd0;
            beat_reg      <= 3'd0;
            store_reg     <= 1'b0;
            owner_lsb_reg <= 1'b0;
            result_reg    <= 32'd0;
            if_done_reg   <= 1'b0;
            lsb_done_reg  <= 1'b0;
            if_data_reg   <= 32'd0;
            lsb_rdata_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            len_reg       <= len_next;
            beat_reg      <= beat_next;
            store_reg     <= store_next;
            owner_lsb_reg <= owner_lsb_next;
            result_reg    <= result_next;
            if_done_reg   <= if_done_next;
            lsb_done_reg  <= lsb_done_next;
            if_data_reg   <= if_data_next;
            lsb_rdata_reg <= lsb_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        len_next       = len_reg;
        beat_next      = beat_reg;
        store_next     = store_reg;
        owner_lsb_next = owner_lsb_reg;
        result_next    = result_reg;
        if_done_next   = if_done_reg & ~rdy_in;
        lsb_done_next  = lsb_done_reg & ~rdy_in;
        if_data_next   = if_data_reg;
        lsb_rdata_next = lsb_rdata_reg;

        if (rdy_in) begin
            case (state_reg)
                IDLE: begin
                    if (!clear) begin
                        if (lsb_req && !lsb_done_reg) begin
                            addr_next      = lsb_addr;
                            wdata_next     = lsb_wdata;
                            len_next       = size_len(lsb_size);
                            store_next     = lsb_wr;
                            owner_lsb_next = 1'b1;
                            beat_next      = 3'd0;
                            result_next    = 32'd0;
                            state_next     = (lsb_wr && lsb_addr[17:16] == 2'b11 && io_buffer_full)
                                             ? IO_WAIT : XFER;
                        end else if (if_req && !if_done_reg) begin
                            addr_next      = if_addr;
                            wdata_next     = 32'd0;
                            len_next       = 3'd4;
                            store_next     = 1'b0;
                            owner_lsb_next = 1'b0;
                            beat_next      = 3'd0;
                            result_next    = 32'd0;
                            state_next     = XFER;
                        end
                    end
                end
                IO_WAIT: begin
                    if (!io_buffer_full) state_next = XFER;
                end
                XFER: begin
                    if (!store_reg && beat_reg != 3'd0) result_next = result_cap;
                    // Reads can be flushed; stores always run to completion.
                    if (clear && !store_reg) begin
                        state_next = IDLE;
                    end else if (beat_reg == len_reg) begin
                        state_next = IDLE;
                        if (owner_lsb_reg) begin
                            lsb_done_next = 1'b1;
                            if (!store_reg) lsb_rdata_next = result_next;
                        end else begin
                            if_done_next = 1'b1;
                            if_data_next = result_next;
                        end
                    end else begin
                        beat_next = beat_reg + 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model answers the bus, monitors check
// done data and every write against queues filled by the directed stimulus.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        if_req, lsb_req, lsb_wr, io_buffer_full;
    logic [31:0] if_addr, lsb_addr, lsb_wdata;
    logic [1:0]  lsb_size;
    logic        if_done, lsb_done, mem_wr, busy;
    logic [31:0] if_data, lsb_rdata, mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'h00;

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fixed contents plus a small writable window at 0x500..0x503.
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h13;
            32'h0000_1004: return 8'h93;
            32'h0000_1006: return 8'h10;
            32'h0000_2000: return 8'h55;
            32'h0000_0002: return 8'hFF;
            32'h0000_0003: return 8'h80;
            32'hFFFF_FFFE: return 8'h11;
            32'hFFFF_FFFF: return 8'h22;
            32'h0000_0000: return 8'h33;
            32'h0000_0001: return 8'h44;
            32'h0000_0010: return 8'hAB;
            default:       return 8'h00;
        endcase
    endfunction

    logic [7:0] wram [4] = '{default: 8'h00};

    always @(posedge clk_in) begin
        if (mem_a[31:2] == 30'h140) mem_din <= wram[mem_a[1:0]];
        else                        mem_din <= rom_byte(mem_a);
        if (mem_wr && mem_a[31:2] == 30'h140) wram[mem_a[1:0]] <= mem_dout;
    end

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } lsb_exp_t;

    logic [31:0] if_q [$];
    lsb_exp_t    lsb_q [$];
    logic [39:0] wr_q [$];
    logic [31:0] if_exp;
    lsb_exp_t    lsb_exp;
    logic [39:0] wr_exp;

    always @(negedge clk_in) begin
        if (if_done) begin
            $display("if_done   data=%h", if_data);
            if (if_q.size() == 0) check("if_done_unexpected", 32'(if_done), 32'd0);
            else begin
                if_exp = if_q.pop_front();
                check("if_data", if_data, if_exp);
            end
        end
        if (lsb_done) begin
            $display("lsb_done  rdata=%h", lsb_rdata);
            if (lsb_q.size() == 0) check("lsb_done_unexpected", 32'(lsb_done), 32'd0);
            else begin
                lsb_exp = lsb_q.pop_front();
                if (lsb_exp.chk) check("lsb_rdata", lsb_rdata, lsb_exp.data);
            end
        end
        if (mem_wr) begin
            $display("write     addr=%h data=%h", mem_a, mem_dout);
            if (wr_q.size() == 0) check("write_unexpected", 32'(mem_wr), 32'd0);
            else begin
                wr_exp = wr_q.pop_front();
                check("write_addr", mem_a, wr_exp[39:8]);
                check("write_data", 32'(mem_dout), 32'(wr_exp[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic samp();
        @(negedge clk_in);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
        if_addr = a;
        if_req  = 1'b1;
        if_q.push_back(exp);
        for (int k = 0; k < 4; k++) begin
            step(); samp();
            check({tag, "_addr"}, mem_a, a + 32'(k));
        end
        step(); samp(); check({tag, "_early"}, 32'(if_done), 32'd0);
        step(); samp(); check({tag, "_done"}, 32'(if_done), 32'd1);
        step(); if_req = 1'b0;
    endtask

    task automatic lsb_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int exp_lat, input string tag);
        int lat;
        lat       = 0;
        lsb_req   = 1'b1;
        lsb_wr    = w;
        lsb_size  = sz;
        lsb_addr  = a;
        lsb_wdata = wd;
        do begin
            step(); samp();
            lat++;
        end while (!lsb_done && lat < 30);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        step();
        lsb_req = 1'b0;
        lsb_wr  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        step(); step(); samp();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        step(); rst_in = 1'b1;
        step();

        // Plain word fetch.
        fetch(32'h0000_1000, 32'h0000_0013, "fetch1000");

        // Simultaneous requests: store wins, waits on full UART buffer, then fetch runs.
        if_addr = 32'h0000_1004; if_req = 1'b1;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b00;
        lsb_addr = 32'h0003_0000; lsb_wdata = 32'h0000_0041; io_buffer_full = 1'b1;
        lsb_q.push_back('{1'b0, 32'd0});
        wr_q.push_back({32'h0003_0000, 8'h41});
        if_q.push_back(32'h0010_0093);
        step(); samp(); check("io_busy", 32'(busy), 32'd1); check("io_wait_wr1", 32'(mem_wr), 32'd0);
        step(); samp(); check("io_wait_wr2", 32'(mem_wr), 32'd0);
        step(); io_buffer_full = 1'b0; samp(); check("io_wait_wr3", 32'(mem_wr), 32'd0);
        step(); samp(); check("io_write_wr", 32'(mem_wr), 32'd1);
        step(); samp(); check("io_tail_wr", 32'(mem_wr), 32'd0);
        step(); samp(); check("io_lsb_done", 32'(lsb_done), 32'd1); check("io_if_not_done", 32'(if_done), 32'd0);
        step(); lsb_req = 1'b0; lsb_wr = 1'b0;
        samp(); check("io_fetch_start", mem_a, 32'h0000_1004);
        repeat (4) step();
        samp(); check("io_fetch_early", 32'(if_done), 32'd0);
        step(); samp(); check("io_fetch_done", 32'(if_done), 32'd1);
        step(); if_req = 1'b0;

        // Flush a fetch during its third byte.
        if_addr = 32'h0000_2000; if_req = 1'b1;
        step(); step(); step();
        clear = 1'b1; if_req = 1'b0;
        samp(); check("clr_fetch_byte2", mem_a, 32'h0000_2002);
        step(); clear = 1'b0;
        samp(); check("clr_fetch_idle", 32'(busy), 32'd0); check("clr_fetch_bus", mem_a, 32'd0);
        repeat (6) step();

        // A store ignores clear and completes.
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'b10;
        lsb_addr = 32'h0000_0100; lsb_wdata = 32'hDEAD_BEEF;
        lsb_q.push_back('{1'b0, 32'd0});
        wr_q.push_back({32'h0000_0100, 8'hEF});
        wr_q.push_back({32'h0000_0101, 8'hBE});
        wr_q.push_back({32'h0000_0102, 8'hAD});
        wr_q.push_back({32'h0000_0103, 8'hDE});
        step(); samp(); check("clr_store_wr", 32'(mem_wr), 32'd1);
        step(); clear = 1'b1;
        step(); clear = 1'b0;
        step();
        step(); samp(); check("clr_store_early", 32'(lsb_done), 32'd0);
        step(); samp(); check("clr_store_done", 32'(lsb_done), 32'd1);
        step(); lsb_req = 1'b0; lsb_wr = 1'b0;

        // Half load with a stall in byte 0's capture cycle.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b01; lsb_addr = 32'h0000_0002;
        lsb_q.push_back('{1'b1, 32'h0000_80FF});
        step(); samp(); check("stall_b0", mem_a, 32'h0000_0002);
        step(); rdy_in = 1'b0;
        samp(); check("stall_reissue", mem_a, 32'h0000_0002); check("stall_wr", 32'(mem_wr), 32'd0);
        step(); rdy_in = 1'b1;
        samp(); check("stall_b1", mem_a, 32'h0000_0003);
        step(); samp(); check("stall_early", 32'(lsb_done), 32'd0);
        step(); samp(); check("stall_done", 32'(lsb_done), 32'd1);
        step(); lsb_req = 1'b0;

        // Address wraps past 0xFFFFFFFF.
        fetch(32'hFFFF_FFFE, 32'h4433_2211, "wrap");

        // Store half then read it back as a word; byte load boundary.
        wr_q.push_back({32'h0000_0500, 8'hC3});
        wr_q.push_back({32'h0000_0501, 8'hA5});
        lsb_q.push_back('{1'b0, 32'd0});
        lsb_txn(1'b1, 2'b01, 32'h0000_0500, 32'h1234_A5C3, 4, "st_half");
        lsb_q.push_back('{1'b1, 32'h0000_A5C3});
        lsb_txn(1'b0, 2'b10, 32'h0000_0500, 32'd0, 6, "ld_word");
        lsb_q.push_back('{1'b1, 32'h0000_0013});
        lsb_txn(1'b0, 2'b00, 32'h0000_1000, 32'd0, 3, "ld_byte");
        lsb_q.push_back('{1'b1, 32'h0000_0013});
        lsb_txn(1'b0, 2'b11, 32'h0000_1000, 32'd0, 6, "ld_size3");

        // Asynchronous reset in the middle of a load.
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'b10; lsb_addr = 32'h0000_0010;
        step(); step();
        rst_in = 1'b0; lsb_req = 1'b0;
        #1;
        check("arst_mem_a", mem_a, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_if_data", if_data, 32'd0);
        check("arst_lsb_rdata", lsb_rdata, 32'd0);
        step(); step(); rst_in = 1'b1;
        repeat (6) step();
        fetch(32'h0000_1000, 32'h0000_0013, "after_rst");

        repeat (2) step();
        check("if_q_empty", 32'(if_q.size()), 32'd0);
        check("lsb_q_empty", 32'(lsb_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
